// File: rtl/divfreq_gen.sv
// Parameterised 50%-duty clock divider: CLK_div toggles every HALF enabled CLK cycles.
// Optional macro DIVFREQ_TICK_EN adds a one-cycle registered 'tick' on each CLK_div rising edge.
module divfreq_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int OUT_HZ = 10
) (
    input  logic CLK,
    input  logic init,
    input  logic en,
    output logic CLK_div
`ifdef DIVFREQ_TICK_EN
    ,
    output logic tick
`endif
);

    // The divisor is guarded so a zero OUT_HZ reaches the $error below instead of a divide-by-zero.
    localparam int OUT_SAFE = (OUT_HZ > 0) ? OUT_HZ : 1;
    localparam int RATIO    = CLK_HZ / (2 * OUT_SAFE);
    localparam int HALF     = (RATIO < 1) ? 1 : RATIO;
    localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    generate
        if (OUT_HZ == 0 || CLK_HZ == 0) begin : g_bad_params
            $error("divfreq_gen: CLK_HZ and OUT_HZ must both be non-zero");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clk_div_q;
    logic          clk_div_d;
    logic          wrap;

    always_comb begin
        cnt_d     = cnt_q;
        clk_div_d = clk_div_q;
        wrap      = en && (cnt_q == LAST);
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d     = '0;
                clk_div_d = ~clk_div_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge init) begin
        if (!init) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign CLK_div = clk_div_q;

`ifdef DIVFREQ_TICK_EN
    logic tick_q;
    logic tick_d;

    // Fires on the same edge that takes CLK_div from 0 to 1.
    always_comb begin
        tick_d = wrap && !clk_div_q;
    end

    always_ff @(posedge CLK or negedge init) begin
        if (!init) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
`endif

endmodule

// File: tb/tb_divfreq_gen.sv
// Directed bench for divfreq_gen: HALF=5 main instance plus HALF=1 and truncated HALF=6 instances.
module tb_divfreq_gen;

    logic clk;
    logic init;
    logic en;
    logic en_on;
    logic div5;
    logic div1;
    logic div6;
    logic tick5;
    logic tick1;
    logic tick6;

    int n_cmp;
    int n_bad;

    // HALF = 20/(2*2) = 5
    divfreq_gen #(.CLK_HZ(20), .OUT_HZ(2)) dut5 (
        .CLK(clk), .init(init), .en(en), .CLK_div(div5)
`ifdef DIVFREQ_TICK_EN
        , .tick(tick5)
`endif
    );

    // HALF = 10/(2*10) = 0 -> clamped to 1
    divfreq_gen #(.CLK_HZ(10), .OUT_HZ(10)) dut1 (
        .CLK(clk), .init(init), .en(en_on), .CLK_div(div1)
`ifdef DIVFREQ_TICK_EN
        , .tick(tick1)
`endif
    );

    // HALF = floor(25/4) = 6
    divfreq_gen #(.CLK_HZ(25), .OUT_HZ(2)) dut6 (
        .CLK(clk), .init(init), .en(en_on), .CLK_div(div6)
`ifdef DIVFREQ_TICK_EN
        , .tick(tick6)
`endif
    );

`ifndef DIVFREQ_TICK_EN
    assign tick5 = 1'b0;
    assign tick1 = 1'b0;
    assign tick6 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic init;
        logic en;
        logic d5;
        logic d1;
        logic d6;
        logic t5;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic i, input logic e, input logic d5, input logic d1,
                       input logic d6, input logic t5);
        vec_t v;
        v.init = i; v.en = e; v.d5 = d5; v.d1 = d1; v.d6 = d6; v.t5 = t5;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        init  = 1'b0;
        en    = 1'b1;
        en_on = 1'b1;

        // Reset hold: 10 cycles with init low and en high.
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 0);
        // Edges 1..16 after release.
        add(1, 1, 0, 1, 0, 0);   // 1
        add(1, 1, 0, 0, 0, 0);   // 2
        add(1, 1, 0, 1, 0, 0);   // 3
        add(1, 1, 0, 0, 0, 0);   // 4
        add(1, 1, 1, 1, 0, 1);   // 5  first rise of div5
        add(1, 1, 1, 0, 1, 0);   // 6  first rise of div6
        add(1, 1, 1, 1, 1, 0);   // 7
        add(1, 1, 1, 0, 1, 0);   // 8
        add(1, 1, 1, 1, 1, 0);   // 9
        add(1, 1, 0, 0, 1, 0);   // 10 div5 falls
        add(1, 1, 0, 1, 1, 0);   // 11
        add(1, 1, 0, 0, 0, 0);   // 12 div6 falls
        add(1, 1, 0, 1, 0, 0);   // 13
        add(1, 1, 0, 0, 0, 0);   // 14
        add(1, 1, 1, 1, 0, 1);   // 15 second rise of div5
        add(1, 1, 1, 0, 0, 0);   // 16

        for (int k = 0; k < vecs.size(); k++) begin
            init = vecs[k].init;
            en   = vecs[k].en;
            step();
            check($sformatf("div5[v%0d]", k), div5, vecs[k].d5);
            check($sformatf("div1[v%0d]", k), div1, vecs[k].d1);
            check($sformatf("div6[v%0d]", k), div6, vecs[k].d6);
`ifdef DIVFREQ_TICK_EN
            check($sformatf("tick5[v%0d]", k), tick5, vecs[k].t5);
`endif
            if (!vecs[k].init) check($sformatf("cnt0[v%0d]", k), (dut5.cnt_q == 3'd0), 1'b1);
            $display("vec %0d init=%b en=%b div5=%b div1=%b div6=%b tick5=%b",
                     k, init, en, div5, div1, div6, tick5);
        end

        // Async reset while div5 is high: must clear before the next edge.
        check("pre_async_div5", div5, 1'b1);
        init = 1'b0;
        #1;
        check("async_div5", div5, 1'b0);
        check("async_tick5", tick5, 1'b0);
        $display("async reset mid-run div5=%b", div5);
        step();
        step();

        // Enable freeze: 3 enabled, 7 frozen, then rise on the 2nd re-enabled edge.
        init = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            en = (e >= 4 && e <= 10) ? 1'b0 : 1'b1;
            step();
            check($sformatf("freeze_div5[e%0d]", e), div5, (e == 12));
`ifdef DIVFREQ_TICK_EN
            check($sformatf("freeze_tick5[e%0d]", e), tick5, (e == 12));
`endif
            $display("freeze edge %0d en=%b div5=%b tick5=%b", e, en, div5, tick5);
        end

        // Second async reset with div5 high, then rise again 5 edges after release.
        init = 1'b0;
        #1;
        check("async2_div5", div5, 1'b0);
        step();
        init = 1'b1;
        en   = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            check($sformatf("rerun_div5[e%0d]", e), div5, (e >= 5));
`ifdef DIVFREQ_TICK_EN
            check($sformatf("rerun_tick5[e%0d]", e), tick5, (e == 5));
`endif
            $display("rerun edge %0d div5=%b tick5=%b", e, div5, tick5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
